demux_rr_scheduler: RTL and testbench



---
 rtl/demux_rr_scheduler.sv | 127 ++++++++++++
 tb/tb_demux_rr_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : demux_rr_scheduler
// Description : Upstream scheduler for a 3-bit demultiplexer (sel, a -> f[7:0]).
//               Takes single-bit items over a valid/ready handshake, assigns
//               each to the next enabled channel in round-robin order, drives
//               sel/a for DWELL cycles, then holds sel with a=0 for GAP cycles
//               before it can accept the next item.
// Ports       : clk       - rising-edge clock
//               rst       - synchronous active-high reset
//               in_valid  - upstream item valid
//               in_data   - item value to route
//               in_ready  - scheduler can accept an item this cycle (comb.)
//               chan_mask - per-channel enable, bit i enables channel i
//               sel       - registered channel select to the demux
//               a         - registered data to the demux
//               busy      - registered, high whenever not idle
// Revision    : 1.0 - initial release
// ============================================================================
module demux_rr_scheduler #(
    parameter int DWELL = 4,
    parameter int GAP   = 1,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_data,
    output logic       in_ready,
    input  logic [7:0] chan_mask,
    output logic [2:0] sel,
    output logic       a,
    output logic       busy
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_drive = 2'd1;
    localparam logic [1:0] c_st_gap   = 2'd2;

    localparam logic [CNT_W-1:0] c_dwell_ld = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] c_gap_ld   = CNT_W'((GAP > 0) ? (GAP - 1) : 0);
    localparam bit               c_has_gap  = (GAP > 0);

    logic [1:0]       r_state;
    logic [2:0]       r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_sel;
    logic             r_a;
    logic             r_busy;

    logic [2:0]       w_nxt;
    logic             w_accept;

    // Round-robin search: offsets are scanned from farthest (ptr+8 == ptr)
    // to nearest (ptr+1), so the nearest enabled channel overwrites the
    // others and wins. With no bit set the result is unused (in_ready=0).
    always_comb begin
        w_nxt = r_ptr;
        for (int i = 8; i >= 1; i--) begin
            if (chan_mask[3'(r_ptr + 3'(i))]) begin
                w_nxt = 3'(r_ptr + 3'(i));
            end
        end
    end

    assign in_ready = (r_state == c_st_idle) && (chan_mask != 8'd0) && !rst;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_sel   <= 3'd0;
            r_a     <= 1'b0;
            r_busy  <= 1'b0;
            r_ptr   <= 3'd7;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_sel   <= w_nxt;
                        r_ptr   <= w_nxt;
                        r_a     <= in_data;
                        r_cnt   <= c_dwell_ld;
                        r_busy  <= 1'b1;
                        r_state <= c_st_drive;
                    end else begin
                        r_a <= 1'b0;
                    end
                end
                c_st_drive: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_a <= 1'b0;
                        if (c_has_gap) begin
                            r_cnt   <= c_gap_ld;
                            r_state <= c_st_gap;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= c_st_idle;
                        end
                    end
                end
                c_st_gap: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_a     <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign sel  = r_sel;
    assign a    = r_a;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_demux_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_rr_scheduler
// Description : Self-checking bench for demux_rr_scheduler. Two instances
//               (DWELL=4/GAP=1 and DWELL=1/GAP=0) share one stimulus stream
//               and are each compared every cycle against an item-timeline
//               reference model: an accepted item is described by its
//               channel, its value and its age in cycles since acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_rr_scheduler;

    localparam int c_dwell [2] = '{4, 1};
    localparam int c_gap   [2] = '{1, 0};

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_data;
    logic [7:0] chan_mask;

    logic       rdy_a, a_a, busy_a;
    logic [2:0] sel_a;
    logic       rdy_b, a_b, busy_b;
    logic [2:0] sel_b;

    always #5 clk = ~clk;

    demux_rr_scheduler #(.DWELL(4), .GAP(1), .CNT_W(8)) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (rdy_a),
        .chan_mask(chan_mask),
        .sel      (sel_a),
        .a        (a_a),
        .busy     (busy_a)
    );

    demux_rr_scheduler #(.DWELL(1), .GAP(0), .CNT_W(8)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (rdy_b),
        .chan_mask(chan_mask),
        .sel      (sel_b),
        .a        (a_b),
        .busy     (busy_b)
    );

    // Reference model: per instance, the last routed item and its age.
    int m_ptr   [2];
    int m_sel   [2];
    int m_data  [2];
    int m_age   [2];
    int m_items [2];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    bit   cap_en = 1'b0;
    logic prev_busy_a = 1'b0;
    int   cap_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic get_rdy(input int i);
        return (i == 0) ? rdy_a : rdy_b;
    endfunction

    function automatic logic [2:0] get_sel(input int i);
        return (i == 0) ? sel_a : sel_b;
    endfunction

    function automatic logic get_a(input int i);
        return (i == 0) ? a_a : a_b;
    endfunction

    function automatic logic get_busy(input int i);
        return (i == 0) ? busy_a : busy_b;
    endfunction

    // One clock cycle: apply inputs, check in_ready, advance the model at
    // the edge, then check the registered outputs just after it.
    task automatic step(input logic r, input logic v, input logic d, input logic [7:0] m);
        bit acc [2];
        int per;
        int nxt;
        bit found;
        rst = r; in_valid = v; in_data = d; chan_mask = m;
        #1;
        for (int i = 0; i < 2; i++) begin
            per    = c_dwell[i] + c_gap[i];
            acc[i] = v && !r && (m != 8'd0) && (m_age[i] >= per);
            check($sformatf("in_ready[%0d]", i), 32'(get_rdy(i)),
                  32'(!r && (m != 8'd0) && (m_age[i] >= per)));
        end
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            per = c_dwell[i] + c_gap[i];
            if (r) begin
                m_ptr[i] = 7; m_sel[i] = 0; m_data[i] = 0; m_age[i] = per;
            end else if (acc[i]) begin
                found = 1'b0;
                nxt   = m_ptr[i];
                for (int k = 1; k <= 8; k++) begin
                    if (!found && m[(m_ptr[i] + k) % 8]) begin
                        nxt   = (m_ptr[i] + k) % 8;
                        found = 1'b1;
                    end
                end
                m_ptr[i]  = nxt;
                m_sel[i]  = nxt;
                m_data[i] = int'(d);
                m_age[i]  = 0;
                m_items[i]++;
            end else if (m_age[i] < per) begin
                m_age[i]++;
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            per = c_dwell[i] + c_gap[i];
            check($sformatf("sel[%0d]", i), 32'(get_sel(i)), 32'(m_sel[i]));
            check($sformatf("a[%0d]", i), 32'(get_a(i)),
                  (m_age[i] < c_dwell[i]) ? 32'(m_data[i]) : 32'd0);
            check($sformatf("busy[%0d]", i), 32'(get_busy(i)), 32'(m_age[i] < per));
        end
        if (cap_en && busy_a && !prev_busy_a) cap_q.push_back(int'(sel_a));
        prev_busy_a = busy_a;
    endtask

    initial begin
        logic [7:0] rmask;
        for (int i = 0; i < 2; i++) begin
            m_ptr[i] = 7; m_sel[i] = 0; m_data[i] = 0;
            m_age[i] = c_dwell[i] + c_gap[i]; m_items[i] = 0;
        end

        // Reset and round-robin over all channels.
        step(1, 0, 0, 8'hFF);
        step(1, 0, 0, 8'hFF);
        check("reset sel_a", 32'(sel_a), 32'd0);
        check("reset busy_a", 32'(busy_a), 32'd0);
        for (int c = 0; c < 20; c++) step(0, 1, 1, 8'hFF);

        // Sparse mask with wrap, sequence captured from the DUT.
        step(1, 0, 0, 8'hA4);
        cap_en = 1'b1;
        for (int c = 0; c < 30; c++) step(0, 1, 1, 8'hA4);
        cap_en = 1'b0;
        check("cap count", 32'(cap_q.size() >= 4), 32'd1);
        if (cap_q.size() >= 4) begin
            check("cap sel0", 32'(cap_q[0]), 32'd2);
            check("cap sel1", 32'(cap_q[1]), 32'd5);
            check("cap sel2", 32'(cap_q[2]), 32'd7);
            check("cap sel3", 32'(cap_q[3]), 32'd2);
        end

        // Empty mask holds off acceptance, then a single channel.
        for (int c = 0; c < 8; c++) step(0, 0, 0, 8'hA4);
        for (int c = 0; c < 20; c++) step(0, 1, 1, 8'h00);
        for (int c = 0; c < 8; c++) step(0, 1, 1, 8'h10);

        // Mask change while an item is in flight.
        step(1, 0, 0, 8'hFF);
        for (int c = 0; c < 9; c++) step(0, 1, 1, 8'hFF);
        for (int c = 0; c < 12; c++) step(0, 1, 1, 8'h01);

        // Reset in the middle of a dwell.
        step(1, 0, 0, 8'hFF);
        for (int c = 0; c < 3; c++) step(0, 1, 1, 8'hFF);
        step(1, 1, 1, 8'hFF);
        check("midreset a_a", 32'(a_a), 32'd0);
        for (int c = 0; c < 8; c++) step(0, 1, 1, 8'hFF);

        // Alternating item values, paced by the fast instance.
        step(1, 0, 0, 8'hFF);
        m_items[1] = 0;
        for (int c = 0; c < 24; c++) step(0, 1, (m_items[1] % 2) == 0, 8'hFF);

        // Randomized traffic.
        rmask = 8'hFF;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0:       rmask = 8'h00;
                    1:       rmask = 8'(1 << $urandom_range(0, 7));
                    default: rmask = 8'($urandom);
                endcase
            end
            step($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0,
                 1'($urandom), rmask);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
